// File: rtl/layer_compositor.sv
// Priority compositor for N colour layers with colour-key transparency and a
// per-frame overlap counter between two selectable layers. Two-stage pipeline.
module layer_compositor #(
    parameter int                N_LAYERS   = 4,
    parameter int                COL_W      = 16,
    parameter int                IDX_W      = 13,
    parameter logic [COL_W-1:0]  KEY_COLOUR = 16'h0000,
    parameter logic [COL_W-1:0]  BG_COLOUR  = 16'h0000,
    parameter int                CNT_W      = 13,
    localparam int               LW         = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_begin,
    input  logic                     pixel_valid,
    input  logic [IDX_W-1:0]         pixel_index,
    input  logic [N_LAYERS*COL_W-1:0] layer_col,
    input  logic [N_LAYERS-1:0]      layer_en_next,
    input  logic [N_LAYERS*LW-1:0]   prio_next,
    input  logic [LW-1:0]            ovl_a_sel,
    input  logic [LW-1:0]            ovl_b_sel,
    output logic                     out_valid,
    output logic [IDX_W-1:0]         out_index,
    output logic [COL_W-1:0]         out_col,
    output logic [CNT_W-1:0]         ovl_count,
    output logic                     ovl_flag,
    output logic                     cfg_error
);

    localparam logic [LW:0]       N_LIM   = (LW+1)'(N_LAYERS);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [LW-1:0] slot_next [N_LAYERS];
    logic          prio_ok;
    logic          load_cfg;

    logic [N_LAYERS-1:0]    en_q;
    logic [N_LAYERS*LW-1:0] prio_q;
    logic [LW-1:0]          a_q, b_q;
    logic                   cfg_err_q;

    logic [N_LAYERS-1:0]    en_eff;
    logic [N_LAYERS*LW-1:0] prio_eff;
    logic [LW-1:0]          a_eff, b_eff;
    logic [N_LAYERS-1:0]    opaque;
    logic                   hit;

    logic                     v1_q;
    logic [IDX_W-1:0]         idx1_q;
    logic [N_LAYERS-1:0]      opq1_q;
    logic [N_LAYERS*COL_W-1:0] col1_q;
    logic [N_LAYERS*LW-1:0]   prio1_q;

    logic [COL_W-1:0] pick_col;
    logic             pick_found;
    logic [LW-1:0]    pick_slot;

    logic             out_valid_q;
    logic [IDX_W-1:0] out_index_q;
    logic [COL_W-1:0] out_col_q;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] ovl_count_q;
    logic             ovl_flag_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_LAYERS; gi++) begin : g_layer
            assign slot_next[gi] = prio_next[gi*LW +: LW];
            assign opaque[gi]    = en_eff[gi] && (layer_col[gi*COL_W +: COL_W] != KEY_COLOUR);
        end
    endgenerate

    // Permutation check: every slot in range and no two slots naming the same layer.
    always_comb begin
        prio_ok = 1'b1;
        for (int k = 0; k < N_LAYERS; k++) begin
            if ({1'b0, slot_next[k]} >= N_LIM) prio_ok = 1'b0;
            for (int j = 0; j < k; j++) begin
                if (slot_next[j] == slot_next[k]) prio_ok = 1'b0;
            end
        end
    end

    // An accepted config already governs the pixel arriving with frame_begin.
    assign load_cfg = frame_begin && prio_ok;
    assign en_eff   = load_cfg ? layer_en_next : en_q;
    assign prio_eff = load_cfg ? prio_next     : prio_q;
    assign a_eff    = load_cfg ? ovl_a_sel     : a_q;
    assign b_eff    = load_cfg ? ovl_b_sel     : b_q;
    assign hit      = pixel_valid && opaque[a_eff] && opaque[b_eff];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q      <= '1;
            for (int k = 0; k < N_LAYERS; k++) prio_q[k*LW +: LW] <= LW'(k);
            a_q       <= '0;
            b_q       <= LW'(1);
            cfg_err_q <= 1'b0;
        end else if (frame_begin) begin
            if (prio_ok) begin
                en_q   <= layer_en_next;
                prio_q <= prio_next;
                a_q    <= ovl_a_sel;
                b_q    <= ovl_b_sel;
            end
            cfg_err_q <= !prio_ok;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q    <= 1'b0;
            idx1_q  <= '0;
            opq1_q  <= '0;
            col1_q  <= '0;
            prio1_q <= '0;
        end else begin
            v1_q    <= pixel_valid;
            idx1_q  <= pixel_index;
            opq1_q  <= opaque;
            col1_q  <= layer_col;
            prio1_q <= prio_eff;
        end
    end

    always_comb begin
        pick_col   = BG_COLOUR;
        pick_found = 1'b0;
        pick_slot  = '0;
        for (int k = 0; k < N_LAYERS; k++) begin
            pick_slot = prio1_q[k*LW +: LW];
            if (!pick_found && opq1_q[pick_slot]) begin
                pick_col   = col1_q[int'(pick_slot)*COL_W +: COL_W];
                pick_found = 1'b1;
            end
        end
    end

    // Index and colour hold through bubbles; only the strobe follows pixel_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_col_q   <= '0;
        end else begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                out_index_q <= idx1_q;
                out_col_q   <= pick_col;
            end
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (frame_begin) acc_d = CNT_W'(hit);
        else if (hit && (acc_q != CNT_MAX)) acc_d = acc_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            ovl_count_q <= '0;
            ovl_flag_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (frame_begin) begin
                ovl_count_q <= acc_q;
                ovl_flag_q  <= (acc_q != '0);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_col   = out_col_q;
    assign ovl_count = ovl_count_q;
    assign ovl_flag  = ovl_flag_q;
    assign cfg_error = cfg_err_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: default instance plus a CNT_W=4 instance
// sharing the same stimulus for the saturation cases.
module tb_layer_compositor;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_begin;
    logic        pixel_valid;
    logic [12:0] pixel_index;
    logic [63:0] layer_col;
    logic [3:0]  layer_en_next;
    logic [7:0]  prio_next;
    logic [1:0]  ovl_a_sel, ovl_b_sel;

    logic        out_valid;
    logic [12:0] out_index;
    logic [15:0] out_col;
    logic [12:0] ovl_count;
    logic        ovl_flag;
    logic        cfg_error;

    logic        out_valid4;
    logic [12:0] out_index4;
    logic [15:0] out_col4;
    logic [3:0]  ovl_count4;
    logic        ovl_flag4;
    logic        cfg_error4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layer_compositor dut (
        .clk(clk), .reset(reset), .frame_begin(frame_begin), .pixel_valid(pixel_valid),
        .pixel_index(pixel_index), .layer_col(layer_col), .layer_en_next(layer_en_next),
        .prio_next(prio_next), .ovl_a_sel(ovl_a_sel), .ovl_b_sel(ovl_b_sel),
        .out_valid(out_valid), .out_index(out_index), .out_col(out_col),
        .ovl_count(ovl_count), .ovl_flag(ovl_flag), .cfg_error(cfg_error)
    );

    layer_compositor #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .frame_begin(frame_begin), .pixel_valid(pixel_valid),
        .pixel_index(pixel_index), .layer_col(layer_col), .layer_en_next(layer_en_next),
        .prio_next(prio_next), .ovl_a_sel(ovl_a_sel), .ovl_b_sel(ovl_b_sel),
        .out_valid(out_valid4), .out_index(out_index4), .out_col(out_col4),
        .ovl_count(ovl_count4), .ovl_flag(ovl_flag4), .cfg_error(cfg_error4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cols(input logic [15:0] c0, c1, c2, c3);
        layer_col = {c3, c2, c1, c0};
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_begin = 1'b0; pixel_valid = 1'b0; pixel_index = '0;
        layer_col = '0; layer_en_next = 4'hF; prio_next = 8'hE4;
        ovl_a_sel = 2'd0; ovl_b_sel = 2'd1;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (out_index !== 13'd0) begin errors++; $display("FAIL reset_out_index got %h expected 0", out_index); end
        checks++; if (out_col !== 16'h0) begin errors++; $display("FAIL reset_out_col got %h expected 0", out_col); end
        checks++; if (ovl_count !== 13'd0) begin errors++; $display("FAIL reset_ovl_count got %0d expected 0", ovl_count); end
        checks++; if (ovl_flag !== 1'b0) begin errors++; $display("FAIL reset_ovl_flag got %b expected 0", ovl_flag); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL reset_cfg_error got %b expected 0", cfg_error); end
        reset = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        set_cols(16'h0000, 16'hF800, 16'h07E0, 16'h001F);
        pixel_valid = 1'b1; pixel_index = 13'd5;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency1 got %b expected 0", out_valid); end
        pixel_index = 13'd6;
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b expected 1", out_valid); end
        checks++; if (out_index !== 13'd5) begin errors++; $display("FAIL basic_index got %0d expected 5", out_index); end
        checks++; if (out_col !== 16'hF800) begin errors++; $display("FAIL basic_col got %h expected f800", out_col); end
        pixel_valid = 1'b0;
        tick();
        checks++; if (out_index !== 13'd6) begin errors++; $display("FAIL basic_index2 got %0d expected 6", out_index); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %b expected 0", out_valid); end
        checks++; if (out_index !== 13'd6) begin errors++; $display("FAIL bubble_index_hold got %0d expected 6", out_index); end
        checks++; if (out_col !== 16'hF800) begin errors++; $display("FAIL bubble_col_hold got %h expected f800", out_col); end
        $display("test_basic done");
    endtask

    task automatic test_prio();
        frame_begin = 1'b1; prio_next = 8'h1B; layer_en_next = 4'b0111;
        ovl_a_sel = 2'd1; ovl_b_sel = 2'd2;
        pixel_valid = 1'b1; pixel_index = 13'd10;
        tick();
        frame_begin = 1'b0; prio_next = 8'hE4; layer_en_next = 4'hF; pixel_index = 13'd11;
        tick();
        checks++; if (out_index !== 13'd10) begin errors++; $display("FAIL prio_index got %0d expected 10", out_index); end
        checks++; if (out_col !== 16'h07E0) begin errors++; $display("FAIL prio_same_cycle_col got %h expected 07e0", out_col); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL prio_cfg_error got %b expected 0", cfg_error); end
        set_cols(16'h0000, 16'h0000, 16'h0000, 16'h0000); pixel_index = 13'd12;
        tick();
        checks++; if (out_col !== 16'h07E0) begin errors++; $display("FAIL prio_next_ignored got %h expected 07e0", out_col); end
        pixel_valid = 1'b0;
        tick();
        checks++; if (out_col !== 16'h0000) begin errors++; $display("FAIL prio_all_key_bg got %h expected 0000", out_col); end
        $display("test_prio done");
    endtask

    task automatic test_cfg_error();
        set_cols(16'h0000, 16'hF800, 16'h07E0, 16'h001F);
        frame_begin = 1'b1; prio_next = 8'h90; layer_en_next = 4'hF;
        pixel_valid = 1'b1; pixel_index = 13'd20;
        tick();
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL cfg_dup_error got %b expected 1", cfg_error); end
        frame_begin = 1'b0; pixel_valid = 1'b0; prio_next = 8'h27;
        tick();
        checks++; if (out_col !== 16'h07E0) begin errors++; $display("FAIL cfg_retained_col got %h expected 07e0", out_col); end
        tick();
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL cfg_error_hold got %b expected 1", cfg_error); end
        frame_begin = 1'b1; pixel_valid = 1'b1; pixel_index = 13'd21;
        tick();
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL cfg_error_clear got %b expected 0", cfg_error); end
        frame_begin = 1'b0; pixel_valid = 1'b0;
        tick();
        checks++; if (out_col !== 16'h001F) begin errors++; $display("FAIL cfg_new_order_col got %h expected 001f", out_col); end
        $display("test_cfg_error done");
    endtask

    task automatic test_overlap();
        frame_begin = 1'b1; pixel_valid = 1'b0;
        tick();
        frame_begin = 1'b0;
        for (int i = 0; i < 6144; i++) begin
            pixel_valid = 1'b1; pixel_index = 13'(i);
            set_cols(16'h0000, 16'hF800, (i < 100) ? 16'h07E0 : 16'h0000, 16'h001F);
            tick();
        end
        pixel_valid = 1'b0; frame_begin = 1'b1;
        tick();
        frame_begin = 1'b0;
        checks++; if (ovl_count !== 13'd100) begin errors++; $display("FAIL ovl_count got %0d expected 100", ovl_count); end
        checks++; if (ovl_flag !== 1'b1) begin errors++; $display("FAIL ovl_flag got %b expected 1", ovl_flag); end
        checks++; if (ovl_count4 !== 4'd15) begin errors++; $display("FAIL ovl_sat100 got %0d expected 15", ovl_count4); end
        set_cols(16'h0000, 16'hF800, 16'h0000, 16'h001F);
        for (int i = 0; i < 50; i++) begin
            pixel_valid = 1'b1; pixel_index = 13'(i);
            tick();
        end
        pixel_valid = 1'b0;
        checks++; if (ovl_count !== 13'd100) begin errors++; $display("FAIL ovl_count_stable got %0d expected 100", ovl_count); end
        frame_begin = 1'b1;
        tick();
        frame_begin = 1'b0;
        checks++; if (ovl_count !== 13'd0) begin errors++; $display("FAIL ovl_none_count got %0d expected 0", ovl_count); end
        checks++; if (ovl_flag !== 1'b0) begin errors++; $display("FAIL ovl_none_flag got %b expected 0", ovl_flag); end
        $display("test_overlap done");
    endtask

    task automatic test_back_to_back();
        set_cols(16'h0000, 16'hF800, 16'h07E0, 16'h001F);
        for (int i = 0; i < 20; i++) begin
            pixel_valid = 1'b1; pixel_index = 13'(i);
            tick();
        end
        frame_begin = 1'b1; pixel_valid = 1'b1;
        tick();
        checks++; if (ovl_count !== 13'd20) begin errors++; $display("FAIL coinc_count got %0d expected 20", ovl_count); end
        checks++; if (ovl_count4 !== 4'd15) begin errors++; $display("FAIL sat20_count got %0d expected 15", ovl_count4); end
        pixel_valid = 1'b0;
        tick();
        checks++; if (ovl_count !== 13'd1) begin errors++; $display("FAIL b2b_restart1 got %0d expected 1", ovl_count); end
        checks++; if (ovl_count4 !== 4'd1) begin errors++; $display("FAIL b2b_restart1_cnt4 got %0d expected 1", ovl_count4); end
        checks++; if (ovl_flag !== 1'b1) begin errors++; $display("FAIL b2b_flag1 got %b expected 1", ovl_flag); end
        tick();
        frame_begin = 1'b0;
        checks++; if (ovl_count !== 13'd0) begin errors++; $display("FAIL b2b_zero got %0d expected 0", ovl_count); end
        checks++; if (ovl_flag !== 1'b0) begin errors++; $display("FAIL b2b_flag0 got %b expected 0", ovl_flag); end
        $display("test_back_to_back done");
    endtask

    task automatic test_same_layer();
        frame_begin = 1'b1; ovl_a_sel = 2'd3; ovl_b_sel = 2'd3; pixel_valid = 1'b0;
        tick();
        frame_begin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pixel_valid = 1'b1; pixel_index = 13'(i);
            set_cols(16'h0000, 16'hF800, 16'h0000, (i < 5) ? 16'h001F : 16'h0000);
            tick();
        end
        pixel_valid = 1'b0; frame_begin = 1'b1;
        tick();
        frame_begin = 1'b0;
        checks++; if (ovl_count !== 13'd5) begin errors++; $display("FAIL same_layer_count got %0d expected 5", ovl_count); end
        $display("test_same_layer done");
    endtask

    task automatic test_reset_midframe();
        set_cols(16'h0000, 16'hF800, 16'h07E0, 16'h001F);
        for (int i = 0; i < 3; i++) begin
            pixel_valid = 1'b1; pixel_index = 13'(40 + i);
            tick();
        end
        pixel_valid = 1'b0; frame_begin = 1'b1; prio_next = 8'h90;
        tick();
        frame_begin = 1'b0; prio_next = 8'h27;
        checks++; if (ovl_count !== 13'd3) begin errors++; $display("FAIL pre_reset_count got %0d expected 3", ovl_count); end
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL pre_reset_cfg_error got %b expected 1", cfg_error); end
        for (int i = 0; i < 3; i++) begin
            pixel_valid = 1'b1; pixel_index = 13'(50 + i);
            tick();
        end
        #1;
        reset = 1'b1; pixel_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b expected 0", out_valid); end
        checks++; if (out_index !== 13'd0) begin errors++; $display("FAIL midrst_index got %0d expected 0", out_index); end
        checks++; if (out_col !== 16'h0) begin errors++; $display("FAIL midrst_col got %h expected 0", out_col); end
        checks++; if (ovl_count !== 13'd0) begin errors++; $display("FAIL midrst_count got %0d expected 0", ovl_count); end
        checks++; if (ovl_flag !== 1'b0) begin errors++; $display("FAIL midrst_flag got %b expected 0", ovl_flag); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL midrst_cfg_error got %b expected 0", cfg_error); end
        tick();
        reset = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL postrst_idle got %b expected 0", out_valid); end
        pixel_valid = 1'b1; pixel_index = 13'd33;
        tick();
        pixel_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL postrst_lat1 got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL postrst_valid got %b expected 1", out_valid); end
        checks++; if (out_col !== 16'hF800) begin errors++; $display("FAIL postrst_cfg_col got %h expected f800", out_col); end
        checks++; if (out_index !== 13'd33) begin errors++; $display("FAIL postrst_index got %0d expected 33", out_index); end
        $display("test_reset_midframe done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prio();
        test_cfg_error();
        test_overlap();
        test_back_to_back();
        test_same_layer();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised, pipelined pixel compositor for the 96x64 OLED path. It merges N sprite/status/background colour layers into one `pixel_data` stream using a per-frame programmable priority order and per-layer enables, with colour-key transparency. It also counts per-frame pixel overlap between two selectable layers, which the game logic uses for hit detection. It sits between the layer generators (status bar, sprites, background) and the OLED driver, replacing the fixed priority mux in the top level.

## Interface
Parameters:
- N_LAYERS, 4, number of input layers (2..8); LW = clog2(N_LAYERS)
- COL_W, 16, colour width (RGB565)
- IDX_W, 13, pixel index width
- KEY_COLOUR, 16'h0000, transparent colour value
- BG_COLOUR, 16'h0000, output colour when no enabled layer is opaque
- CNT_W, 13, overlap counter width

Ports:
- clk  in  1  system clock; one clock domain; every register on rising edge
- reset  in  1  asynchronous, active-high reset
- frame_begin  in  1  one-cycle pulse at start of frame
- pixel_valid  in  1  input pixel strobe
- pixel_index  in  IDX_W  index of the current pixel
- layer_col  in  N_LAYERS*COL_W  layer i colour at [i*COL_W +: COL_W]
- layer_en_next  in  N_LAYERS  enables to apply at next frame_begin
- prio_next  in  N_LAYERS*LW  slot k = layer index; slot 0 is highest priority
- ovl_a_sel, ovl_b_sel  in  LW each  layers monitored for overlap (sampled with config)
- out_valid  out  1  output pixel strobe
- out_index  out  IDX_W  index of the output pixel
- out_col  out  COL_W  composited colour
- ovl_count  out  CNT_W  overlap pixel count of the previous frame
- ovl_flag  out  1  ovl_count != 0
- cfg_error  out  1  last config attempt rejected

## Operation
- Active config registers: en_cur, prio_cur, a_cur, b_cur. Reset values: en_cur all ones; prio_cur identity (slot k = k); a_cur = 0; b_cur = 1.
- On frame_begin, prio_next is checked to be a permutation: every index < N_LAYERS, no duplicates.
  - Valid: all *_next values load into *_cur, and cfg_error clears.
  - Invalid: *_cur are kept and cfg_error sets. cfg_error holds until the next frame_begin that carries a valid config.
- Effective config for a pixel: on a cycle with frame_begin, the newly accepted config applies to that same pixel; on all other cycles, *_cur applies.
- Layer i is opaque when its enable is 1 and its colour differs from KEY_COLOUR.
- Stage 1 registers: pixel_valid, pixel_index, opaque vector, and the layer colours.
- Stage 2: out_col is the colour of the first opaque layer in slot order 0..N_LAYERS-1. If no layer is opaque, out_col = BG_COLOUR. out_valid and out_index are forwarded.
- Overlap accumulator:
  - On each valid pixel where both layer a and layer b are opaque, the accumulator increments, saturating at 2^CNT_W-1.
  - If a == b, the pixel counts whenever that layer is opaque.
- On frame_begin:
  - ovl_count takes the accumulator value from before this cycle.
  - The accumulator restarts at 1 if the coincident pixel overlaps, otherwise at 0.
  - ovl_flag updates together with ovl_count.
- Reset values of outputs: out_valid 0, out_index 0, out_col 0, ovl_count 0, ovl_flag 0, cfg_error 0. The pipeline and the accumulator clear to 0.
- Reset asserted mid-frame clears everything immediately. The first frame after reset uses the reset config until a frame_begin arrives.

## Timing
- Latency: exactly 2 cycles from pixel_valid to out_valid. Throughput is one pixel per cycle, with no stalls and no backpressure.
- pixel_valid low produces a bubble: out_valid goes low 2 cycles later. out_col and out_index hold their last values during the bubble.
- Config changes take effect only at frame_begin. Changes on the *_next inputs between frame_begin pulses are ignored.
- ovl_count, ovl_flag and cfg_error update on the clock edge that samples frame_begin, and are stable for the whole following frame.
- Back-to-back frame_begin pulses are legal. Each pulse latches the count (possibly 0 or 1) and re-evaluates the config.

## Test plan
- Reset, N_LAYERS=4, identity priority; layers {L0=0x0000, L1=0xF800, L2=0x07E0, L3=0x001F}, pixel_valid held high → out_col=0xF800 at cycle+2, out_index matches, out_valid follows with 2-cycle delay.
- prio_next={3,2,1,0} with layer_en_next=4'b0111 at frame_begin; same colours → out_col=0x07E0 (L3 disabled); all layers set to KEY_COLOUR → out_col=BG_COLOUR.
- prio_next with duplicates {0,0,1,2} at frame_begin → cfg_error=1, previous order retained; next frame_begin with valid order → cfg_error=0, new order used.
- Overlap a=1, b=2, both opaque on 100 pixels of a 6144-pixel frame → ovl_count=100 and ovl_flag=1 after the next frame_begin; a frame with no overlap → ovl_count=0, ovl_flag=0.
- frame_begin coincident with an overlapping pixel → previous count latched excluding that pixel; the new frame's accumulator starts at 1. CNT_W=4 with 20 overlaps → ovl_count=15 (saturated).
- Reset asserted mid-frame with the pipeline full → all outputs 0 immediately; out_valid stays 0 until 2 cycles after the next pixel_valid.
